ps2_key_tracker: RTL

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

---
 rtl/ps2_key_tracker.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 key tracker: pops scan-code bytes from an upstream receiver FIFO and
// tracks the single currently held key. It emits one-cycle press/release
// strobes, keeps a two-digit BCD press counter and a sticky overflow flag.
//
// Upstream handshake: rx_ready high means rx_data holds a valid head byte.
// The byte is consumed by a one-cycle low pulse on rx_nextdata_n, which is
// issued only from IDLE. Changes on rx_ready during POP or SETTLE are ignored.
module ps2_key_tracker #(
  parameter int unsigned IGNORE_EXT = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       rx_overflow,
  output logic       rx_nextdata_n,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_down,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count,
  output logic       ovf_sticky,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       nextdata_n_q, nextdata_n_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_down_q, key_down_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
  logic [7:0] count_q, count_d;
  logic       ovf_q, ovf_d;

  logic       held_match;
  logic       is_discard;
  logic [7:0] count_inc;

  // A code byte names the held key only if both code and prefix agree.
  assign held_match = key_down_q && (byte_q == key_code_q) && (ext_q == key_ext_q);

  // Protocol bytes that carry no key information and cancel any prefix.
  always_comb begin
    is_discard = 1'b0;
    case (byte_q)
      8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                                  is_discard = 1'b0;
    endcase
  end

  // Two-digit BCD increment, wrapping 99 back to 00.
  always_comb begin
    count_inc = count_q;
    if (count_q[3:0] == 4'd9) begin
      count_inc[3:0] = 4'd0;
      count_inc[7:4] = (count_q[7:4] == 4'd9) ? 4'd0 : count_q[7:4] + 4'd1;
    end else begin
      count_inc[3:0] = count_q[3:0] + 4'd1;
    end
  end

  // Next-state logic: pop handshake sequencing and byte decode in POP.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    nextdata_n_d = 1'b1;
    brk_d        = brk_q;
    ext_d        = ext_q;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_down_d   = key_down_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    count_d      = count_q;
    ovf_d        = ovf_q | rx_overflow;

    case (state_q)
      IDLE: begin
        if (rx_ready) begin
          byte_d       = rx_data;
          nextdata_n_d = 1'b0;
          state_d      = POP;
        end
      end
      POP: begin
        state_d = SETTLE;
        if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (is_discard) begin
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else begin
          brk_d = 1'b0;
          ext_d = 1'b0;
          if (!(ext_q && (IGNORE_EXT != 0))) begin
            if (brk_q) begin
              if (held_match) begin
                key_down_d = 1'b0;
                key_code_d = 8'h00;
                key_ext_d  = 1'b0;
                release_d  = 1'b1;
              end
            end else if (!held_match) begin
              key_code_d = byte_q;
              key_ext_d  = ext_q;
              key_down_d = 1'b1;
              press_d    = 1'b1;
              count_d    = count_inc;
            end
          end
        end
      end
      SETTLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset drops any byte latched but not yet decoded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      byte_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      key_code_q   <= 8'h00;
      key_ext_q    <= 1'b0;
      key_down_q   <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      count_q      <= 8'h00;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      nextdata_n_q <= nextdata_n_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_down_q   <= key_down_d;
      press_q      <= press_d;
      release_q    <= release_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rx_nextdata_n = nextdata_n_q;
  assign key_code      = key_code_q;
  assign key_ext       = key_ext_q;
  assign key_down      = key_down_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_count   = count_q;
  assign ovf_sticky    = ovf_q;
  assign dbg_state     = state_q;

endmodule
